mux_lut_cell: RTL and testbench
===============================

Name: mux_lut_cell

Overview:
- Runtime-reconfigurable K-input logic cell built as a 2^K:1 mux tree; any K-input Boolean function is selected by its truth table.
- Truth table is loaded serially over a valid/ready config port and committed atomically.
- The evaluation path is registered (valid-tagged, latency 1).
- Replaces hard-wired mux-built gates in the combinational exercises with one parametrised, programmable cell.

Parameters:
K, 2, number of logic inputs (1..6); truth table is 2^K bits.
INIT, {(2**K-1){1'b0}, 1'b1} << (2**K-1) i.e. 4'b1000 for K=2, active truth table after reset (default = K-input AND).

Ports:
clk  input  1  clock, all state on rising edge
rst_n  input  1  asynchronous active-low reset
cfg_valid  input  1  cfg_bit valid this cycle
cfg_ready  output  1  cell accepts a config bit this cycle
cfg_bit  input  1  serial truth-table bit, MSB (index 2^K-1) first
cfg_clear  input  1  synchronous abort of a partial load
cfg_done  output  1  one-cycle pulse when new table becomes active
in_valid  input  1  in_data valid
in_data  input  K  logic inputs; in_data is the truth-table index
out_valid  output  1  out_data valid
out_data  output  1  registered function result
active_cfg  output  2^K  currently active truth table (debug/readback)

Behaviour:
- Reset (rst_n=0, asynchronous):
  - active_cfg=INIT; shadow=0; bit counter=0; state=IDLE.
  - cfg_ready=0 while in reset; cfg_ready=1 in the first cycle after reset release.
  - cfg_done=0, out_valid=0, out_data=0.
- Config FSM, states IDLE, SHIFT, COMMIT:
  - IDLE: cfg_ready=1. A transfer (cfg_valid&cfg_ready) shifts cfg_bit into shadow LSB (shadow<={shadow[2^K-2:0],cfg_bit}), sets cnt=1 and moves to SHIFT. For K such that 2^K=1 (not allowed, K>=1) there is no special case.
  - SHIFT: cfg_ready=1. Each transfer shifts one bit in and increments cnt. On the transfer with cnt==2^K-1 (last bit), go to COMMIT. cfg_valid=0 holds state; gaps of any length are legal.
  - COMMIT (exactly one cycle): cfg_ready=0; active_cfg<=shadow; cfg_done=1 during this cycle; cnt<=0; then IDLE. cfg_valid asserted during COMMIT is ignored (no transfer).
- cfg_clear=1 in IDLE or SHIFT: cnt<=0, shadow<=0, state<=IDLE; any transfer in the same cycle is discarded. cfg_clear in COMMIT has no effect: commit completes.
- active_cfg changes only on the COMMIT edge, never mid-load.
- Evaluation:
  - out_valid<=in_valid every cycle.
  - When in_valid=1: out_data<=active_cfg[in_data], using the table value before the clock edge.
  - When in_valid=0: out_data holds its last value.
  - Latency is exactly 1 cycle, with full throughput (one result per cycle) and no backpressure.
  - The lookup is a binary mux tree of depth K selected by in_data bits, with in_data[0] at the leaf level.
- Simultaneous events: an in_valid sample taken in the COMMIT cycle uses the old table; samples from the following cycle onward use the new table. Evaluation is independent of config traffic in every state.
- Reset mid-load: a partial shadow is lost and active_cfg reverts to INIT, not to the previously committed table.
- Widths: cnt is K+1 bits wide and never exceeds 2^K-1.

Test Plan:
1. Reset, K=2, then apply in_data=0,1,2,3 with in_valid=1 on consecutive cycles -> out_data=0,0,0,1 starting one cycle later; out_valid=1 for 4 cycles; active_cfg=4'b1000.
2. Load 4'b0110 (bits 0,1,1,0, contiguous) -> cfg_ready=0 and cfg_done=1 on the cycle after the 4th transfer; active_cfg=4'b0110; then sweep inputs 0..3 -> out_data=0,1,1,0 (XOR).
3. Load 4'b1110 with random cfg_valid gaps while evaluating in_data=3 every cycle -> out_data=1 (old AND table) through the COMMIT cycle, then stays 1 (OR); then in_data=0 -> 0; active_cfg changes only on the COMMIT edge.
4. Shift 2 bits, assert cfg_clear together with a valid bit, then load 4'b0001 -> the clear-cycle bit is discarded; final active_cfg=4'b0001; in_data=0 -> out_data=1 (NOR).
5. Commit 4'b0110, shift 3 bits, then pulse rst_n low mid-cycle -> outputs clear immediately; after release active_cfg=4'b1000, cnt=0, and a fresh 4-bit load commits correctly.
6. K=3, load 8'b1001_0110 (3-input XOR) and sweep in_data 0..7 -> out_data=0,1,1,0,1,0,0,1. Also assert cfg_valid during COMMIT -> no bit accepted.

Source files
------------

// File: rtl/mux_lut_cell.sv
`default_nettype none
// ============================================================================
//  Module   : mux_lut_cell
//  Purpose  : Runtime-reconfigurable K-input logic cell. The active truth
//             table (2^K bits) drives a binary mux tree selected by in_data,
//             and the result is registered with a valid tag (latency 1).
//             A new table is shifted in serially (MSB first) over a
//             valid/ready port into a shadow register. It is committed
//             atomically in a single COMMIT cycle, so the active table never
//             holds a partially loaded value.
//  Ports    : clk        - clock, all state on rising edge
//             rst_n      - asynchronous active-low reset
//             cfg_valid  - cfg_bit valid this cycle
//             cfg_ready  - cell accepts a config bit this cycle
//             cfg_bit    - serial truth-table bit, index 2^K-1 first
//             cfg_clear  - synchronous abort of a partial load
//             cfg_done   - one-cycle pulse while the new table is committed
//             in_valid   - in_data valid
//             in_data    - logic inputs (truth-table index)
//             out_valid  - out_data valid
//             out_data   - registered function result
//             active_cfg - currently active truth table (readback)
//  Revision : 1.0 - initial release
// ============================================================================
module mux_lut_cell #(
  parameter int K = 2,
  parameter logic [(1<<K)-1:0] INIT = {1'b1, {((1<<K)-1){1'b0}}}
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               cfg_valid,
  output logic               cfg_ready,
  input  logic               cfg_bit,
  input  logic               cfg_clear,
  output logic               cfg_done,
  input  logic               in_valid,
  input  logic [K-1:0]       in_data,
  output logic               out_valid,
  output logic               out_data,
  output logic [(1<<K)-1:0]  active_cfg
);

  localparam int         c_tbl_w    = 1 << K;
  // Index of the last serial bit, 2^K-1, at counter width.
  localparam logic [K:0] c_cnt_last = {1'b0, {K{1'b1}}};
  localparam logic [K:0] c_cnt_one  = {{K{1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SHIFT  = 2'd1,
    ST_COMMIT = 2'd2
  } state_t;

  state_t               r_state;
  state_t               w_state_nxt;
  logic [c_tbl_w-1:0]   r_shadow;
  logic [c_tbl_w-1:0]   w_shadow_nxt;
  logic [K:0]           r_cnt;
  logic [K:0]           w_cnt_nxt;
  logic [c_tbl_w-1:0]   r_active;
  logic                 w_accept;
  logic                 w_lut;

  // ------------------------------------------------------------------------
  // Config state register and shadow/active tables
  // ------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= ST_IDLE;
      r_shadow <= '0;
      r_cnt    <= '0;
      r_active <= INIT;
    end else begin
      r_state  <= w_state_nxt;
      r_shadow <= w_shadow_nxt;
      r_cnt    <= w_cnt_nxt;
      // The active table moves only on the COMMIT edge.
      if (r_state == ST_COMMIT) begin
        r_active <= r_shadow;
      end
    end
  end

  // A bit is taken whenever the port is ready; the COMMIT cycle is the only
  // state that refuses traffic.
  assign w_accept = cfg_valid && (r_state != ST_COMMIT);

  // ------------------------------------------------------------------------
  // Config next-state logic
  // ------------------------------------------------------------------------
  always_comb begin
    w_state_nxt  = r_state;
    w_shadow_nxt = r_shadow;
    w_cnt_nxt    = r_cnt;
    case (r_state)
      ST_IDLE: begin
        if (cfg_clear) begin
          w_shadow_nxt = '0;
          w_cnt_nxt    = '0;
        end else if (w_accept) begin
          w_shadow_nxt = {r_shadow[c_tbl_w-2:0], cfg_bit};
          w_cnt_nxt    = c_cnt_one;
          w_state_nxt  = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (cfg_clear) begin
          // Clear wins over a same-cycle transfer.
          w_shadow_nxt = '0;
          w_cnt_nxt    = '0;
          w_state_nxt  = ST_IDLE;
        end else if (w_accept) begin
          w_shadow_nxt = {r_shadow[c_tbl_w-2:0], cfg_bit};
          if (r_cnt == c_cnt_last) begin
            // Counter is left at its maximum; COMMIT zeroes it.
            w_state_nxt = ST_COMMIT;
          end else begin
            w_cnt_nxt = r_cnt + c_cnt_one;
          end
        end
      end
      ST_COMMIT: begin
        // cfg_clear is deliberately ignored here: the commit always lands.
        w_cnt_nxt   = '0;
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_shadow_nxt = '0;
        w_cnt_nxt    = '0;
        w_state_nxt  = ST_IDLE;
      end
    endcase
  end

  // ------------------------------------------------------------------------
  // Lookup: binary mux tree of depth K. Level l halves the candidate set
  // using in_data[l], so in_data[0] selects at the leaves and in_data[K-1]
  // at the root. Processing in ascending j lets each level overwrite the
  // low half of the working vector in place.
  // ------------------------------------------------------------------------
  always_comb begin
    logic [c_tbl_w-1:0] v_node;
    v_node = r_active;
    for (int l = 0; l < K; l++) begin
      for (int j = 0; j < (c_tbl_w >> (l + 1)); j++) begin
        v_node[j] = in_data[l] ? v_node[2*j+1] : v_node[2*j];
      end
    end
    w_lut = v_node[0];
  end

  // ------------------------------------------------------------------------
  // Registered evaluation stage: full throughput, no backpressure.
  // ------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        out_data <= w_lut;
      end
    end
  end

  // Ready is gated by rst_n so it reads 0 throughout reset and 1 as soon as
  // reset is released.
  assign cfg_ready  = rst_n && (r_state != ST_COMMIT);
  assign cfg_done   = (r_state == ST_COMMIT);
  assign active_cfg = r_active;

endmodule
`default_nettype wire

// File: tb/tb_mux_lut_cell.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mux_lut_cell
//  Purpose  : Self-checking bench for mux_lut_cell. A K=2 cell is driven
//             with directed and random traffic against a truth-table model
//             and scoreboard. A K=3 cell covers a 3-input XOR sweep and a
//             transfer offered during COMMIT.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_mux_lut_cell;

  localparam int             K        = 2;
  localparam int             N        = 1 << K;
  localparam logic [N-1:0]   INIT_TBL = 4'b1000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst_n;
  logic         cfg_valid, cfg_ready, cfg_bit, cfg_clear, cfg_done;
  logic         in_valid, out_valid, out_data;
  logic [K-1:0] in_data;
  logic [N-1:0] active_cfg;

  logic         cfg_valid3, cfg_ready3, cfg_bit3, cfg_clear3, cfg_done3;
  logic         in_valid3, out_valid3, out_data3;
  logic [2:0]   in_data3;
  logic [7:0]   active_cfg3;

  mux_lut_cell #(.K(K)) u_dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cfg_valid  (cfg_valid),
    .cfg_ready  (cfg_ready),
    .cfg_bit    (cfg_bit),
    .cfg_clear  (cfg_clear),
    .cfg_done   (cfg_done),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .out_valid  (out_valid),
    .out_data   (out_data),
    .active_cfg (active_cfg)
  );

  mux_lut_cell #(.K(3)) u_dut3 (
    .clk        (clk),
    .rst_n      (rst_n),
    .cfg_valid  (cfg_valid3),
    .cfg_ready  (cfg_ready3),
    .cfg_bit    (cfg_bit3),
    .cfg_clear  (cfg_clear3),
    .cfg_done   (cfg_done3),
    .in_valid   (in_valid3),
    .in_data    (in_data3),
    .out_valid  (out_valid3),
    .out_data   (out_data3),
    .active_cfg (active_cfg3)
  );

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: active table, received serial bits, pending commit.
  logic         exp_q[$];
  logic         m_bits[$];
  logic [N-1:0] m_tbl;
  logic [N-1:0] m_pend;
  logic         m_commit;
  logic         last_out;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_tbl    = INIT_TBL;
    m_pend   = '0;
    m_commit = 1'b0;
    m_bits.delete();
    exp_q.delete();
    last_out = 1'b0;
  endtask

  // One clock of K=2 traffic; called at posedge+1, returns at posedge+1.
  task automatic step(input logic v, input logic b, input logic clr,
                      input logic iv, input logic [K-1:0] id);
    logic e_ready, e_done;
    cfg_valid = v; cfg_bit = b; cfg_clear = clr;
    in_valid  = iv; in_data = id;
    e_ready = !m_commit;
    e_done  = m_commit;
    if (iv) exp_q.push_back(m_tbl[id]);
    @(negedge clk);
    chk("cfg_ready", cfg_ready, e_ready);
    chk("cfg_done", cfg_done, e_done);
    chk("active_cfg", active_cfg, m_tbl);
    @(posedge clk);
    if (m_commit) begin
      m_tbl    = m_pend;
      m_commit = 1'b0;
    end else if (clr) begin
      m_bits.delete();
    end else if (v) begin
      m_bits.push_back(b);
      if (m_bits.size() == N) begin
        for (int i = 0; i < N; i++) m_pend[N-1-i] = m_bits[i];
        m_commit = 1'b1;
        m_bits.delete();
      end
    end
    #1;
  endtask

  task automatic load(input logic [N-1:0] t, input logic iv, input logic [K-1:0] id);
    for (int i = N - 1; i >= 0; i--) step(1'b1, t[i], 1'b0, iv, id);
  endtask

  // Monitor: pops the scoreboard whenever the DUT presents a result.
  initial begin
    forever begin
      @(negedge clk);
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL out_data: unexpected result %0b with empty scoreboard at %0t", out_data, $time);
        end else begin
          logic e;
          e = exp_q.pop_front();
          chk("out_data", out_data, e);
          last_out = e;
        end
      end else begin
        chk("out_hold", out_data, last_out);
      end
    end
  end

  initial begin
    rst_n = 1'b0;
    cfg_valid = 0; cfg_bit = 0; cfg_clear = 0; in_valid = 0; in_data = '0;
    cfg_valid3 = 0; cfg_bit3 = 0; cfg_clear3 = 0; in_valid3 = 0; in_data3 = '0;
    model_reset();

    // Reset values
    @(negedge clk);
    chk("rst_cfg_ready", cfg_ready, 1'b0);
    chk("rst_cfg_done", cfg_done, 1'b0);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_active", active_cfg, INIT_TBL);
    chk("rst_active3", active_cfg3, 8'h80);
    rst_n = 1'b1;
    #1 chk("ready_after_rst", cfg_ready, 1'b1);
    @(posedge clk); #1;

    // 1: default AND table sweep
    for (int i = 0; i < N; i++) step(0, 0, 0, 1, K'(i));
    step(0, 0, 0, 0, '0);

    // 2: XOR table, contiguous load, then sweep
    load(4'b0110, 1'b0, '0);
    step(0, 0, 0, 0, '0);
    for (int i = 0; i < N; i++) step(0, 0, 0, 1, K'(i));
    step(0, 0, 0, 0, '0);

    // Restore AND so the next load switches AND -> OR under traffic
    load(4'b1000, 1'b0, '0);
    step(0, 0, 0, 0, '0);

    // 3: OR table with random gaps while evaluating in_data=3
    begin
      logic [N-1:0] t;
      t = 4'b1110;
      for (int i = N - 1; i >= 0; i--) begin
        int gap;
        gap = int'($urandom_range(0, 3));
        for (int g = 0; g < gap; g++) step(0, 0, 0, 1, 2'd3);
        step(1, t[i], 0, 1, 2'd3);
      end
    end
    for (int i = 0; i < 3; i++) step(0, 0, 0, 1, 2'd3);
    step(0, 0, 0, 1, 2'd0);
    step(0, 0, 0, 0, '0);

    // 4: partial load, clear with a valid bit, then NOR
    step(1, 1, 0, 0, '0);
    step(1, 0, 0, 0, '0);
    step(1, 1, 1, 0, '0);
    load(4'b0001, 1'b0, '0);
    step(0, 0, 0, 0, '0);
    step(0, 0, 0, 1, 2'd0);
    step(0, 0, 0, 0, '0);

    // 5: reset in the middle of a load after a commit
    load(4'b0110, 1'b0, '0);
    step(0, 0, 0, 0, '0);
    step(1, 1, 0, 1, 2'd1);
    step(1, 0, 0, 1, 2'd2);
    step(1, 1, 0, 1, 2'd3);
    #2 rst_n = 1'b0;
    cfg_valid = 0; cfg_clear = 0; in_valid = 0;
    #1;
    chk("midrst_out_valid", out_valid, 1'b0);
    chk("midrst_out_data", out_data, 1'b0);
    chk("midrst_active", active_cfg, INIT_TBL);
    chk("midrst_ready", cfg_ready, 1'b0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    load(4'b0110, 1'b0, '0);
    step(0, 0, 0, 0, '0);
    for (int i = 0; i < N; i++) step(0, 0, 0, 1, K'(i));

    // Random traffic
    for (int i = 0; i < 300; i++) begin
      step(1'($urandom), 1'($urandom), ($urandom % 16) == 0, 1'($urandom), K'($urandom));
    end
    step(0, 0, 0, 0, '0);
    step(0, 0, 0, 0, '0);

    // 6: K=3 XOR, plus a transfer offered during COMMIT
    begin
      logic [7:0] t3;
      t3 = 8'b1001_0110;
      for (int i = 7; i >= 0; i--) begin
        cfg_valid3 = 1'b1; cfg_bit3 = t3[i];
        @(posedge clk); #1;
      end
      cfg_bit3 = 1'b1;
      chk("k3_commit_ready", cfg_ready3, 1'b0);
      chk("k3_commit_done", cfg_done3, 1'b1);
      chk("k3_commit_old", active_cfg3, 8'h80);
      @(posedge clk); #1;
      cfg_valid3 = 1'b0;
      chk("k3_active", active_cfg3, t3);
      chk("k3_done_low", cfg_done3, 1'b0);
      for (int i = 0; i < 8; i++) begin
        logic [2:0] x;
        x = 3'(i);
        in_valid3 = 1'b1; in_data3 = x;
        @(posedge clk); #1;
        chk("k3_out_valid", out_valid3, 1'b1);
        chk("k3_out_data", out_data3, ^x);
      end
      in_valid3 = 1'b0;
      // Had the COMMIT-cycle bit been taken, 7 more bits would commit.
      for (int i = 0; i < 7; i++) begin
        cfg_valid3 = 1'b1; cfg_bit3 = 1'b1;
        @(posedge clk); #1;
      end
      cfg_valid3 = 1'b0;
      @(posedge clk); #1;
      chk("k3_no_early_commit", cfg_done3, 1'b0);
      chk("k3_still_old", active_cfg3, t3);
      cfg_valid3 = 1'b1;
      @(posedge clk); #1;
      cfg_valid3 = 1'b0;
      chk("k3_commit2", cfg_done3, 1'b1);
      @(posedge clk); #1;
      chk("k3_active2", active_cfg3, 8'hFF);
    end

    @(negedge clk);
    chk("scoreboard_empty", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
